// File: rtl/spm_seq_mult.sv
// spm_seq_mult: serial-parallel multiplier with start/done handshake.
//
// A WIDTH-bit multiplicand x is captured in parallel when start is accepted.
// The multiplier y then arrives serially, LSB first. The 2*WIDTH-bit product
// leaves serially, also LSB first. SIGNED selects unsigned or two's-complement
// operands.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset
//   start    in   multiply request, accepted only while idle
//   x        in   [WIDTH-1:0] parallel multiplicand, sampled on the accept edge
//   y        in   serial multiplier bit, sampled on edges where y_ready==1
//   y_ready  out  y is sampled at the end of this cycle
//   busy     out  operation in progress
//   p        out  serial product bit
//   p_valid  out  p holds a valid product bit
//   done     out  one-cycle pulse that accompanies the last product bit
//   p_par    out  [2*WIDTH-1:0] complete parallel product
//                 (present only when SPM_PAR_OUT_EN is defined)
//
// Optional feature macro: SPM_PAR_OUT_EN. It adds p_par, which holds the
// product from the done cycle until the next multiply shifts in new bits.

module spm_seq_mult #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic             y,
    output logic             y_ready,
    output logic             busy,
    output logic             p,
    output logic             p_valid,
    output logic             done
`ifdef SPM_PAR_OUT_EN
    ,
    output logic [2*WIDTH-1:0] p_par
`endif
);

    localparam int CNT_W = $clog2(2*WIDTH+2);
    localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST_RUN_C = CNT_W'(2*WIDTH-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   carry_q, carry_d;
    logic               ylast_q;
    logic               p_q;
    logic               pvld_q;
    logic               ybit;
    logic [WIDTH-1:0]   sum_shift;

    // Control FSM: next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                y_ready = (cnt_q < WIDTH_C);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_RUN_C) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Carry-save cell array. Once y is exhausted the array is fed the
    // extension bit: zero for unsigned, the y sign bit for signed. In signed
    // mode the MSB cell re-reads its own sum, giving arithmetic sign extension
    // of the partial sum. Any carry that leaves the top cell only affects bits
    // above 2*WIDTH, so the emitted low product bits are exact.
    always_comb begin
        logic [1:0] tot;
        tot       = '0;
        sum_d     = '0;
        carry_d   = '0;
        ybit      = y_ready ? y : ((SIGNED != 0) ? ylast_q : 1'b0);
        sum_shift = {((SIGNED != 0) ? sum_q[WIDTH-1] : 1'b0), sum_q[WIDTH-1:1]};
        for (int i = 0; i < WIDTH; i++) begin
            tot        = {1'b0, x_q[i] & ybit} + {1'b0, sum_shift[i]} + {1'b0, carry_q[i]};
            sum_d[i]   = tot[0];
            carry_d[i] = tot[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            ylast_q <= 1'b0;
            p_q     <= 1'b0;
            pvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && start) begin
                x_q     <= x;
                sum_q   <= '0;
                carry_q <= '0;
                ylast_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                if (y_ready) begin
                    ylast_q <= y;
                end
            end
            // Cell-0 sum becomes the product bit one cycle later.
            p_q    <= (state_q == S_RUN) ? sum_d[0] : 1'b0;
            pvld_q <= (state_q == S_RUN);
        end
    end

    assign p       = p_q;
    assign p_valid = pvld_q;

`ifdef SPM_PAR_OUT_EN
    logic [2*WIDTH-1:0] ppar_q;

    // Bits enter at the top, so after 2*WIDTH shifts bit 0 sits at index 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ppar_q <= '0;
        end else if (state_q == S_RUN) begin
            ppar_q <= {sum_d[0], ppar_q[2*WIDTH-1:1]};
        end
    end

    assign p_par = ppar_q;
`endif

endmodule

// File: tb/tb_spm_seq_mult.sv
module tb_spm_seq_mult;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start_r   [2];
    logic           y_r       [2];
    logic [W-1:0]   x_r       [2];
    logic           y_ready_w [2];
    logic           busy_w    [2];
    logic           p_w       [2];
    logic           pv_w      [2];
    logic           done_w    [2];
`ifdef SPM_PAR_OUT_EN
    logic [2*W-1:0] ppar_w    [2];
`endif

    spm_seq_mult #(.WIDTH(W), .SIGNED(0)) u_uns (
        .clk(clk), .rst(rst), .start(start_r[0]), .x(x_r[0]), .y(y_r[0]),
        .y_ready(y_ready_w[0]), .busy(busy_w[0]), .p(p_w[0]),
        .p_valid(pv_w[0]), .done(done_w[0])
`ifdef SPM_PAR_OUT_EN
        , .p_par(ppar_w[0])
`endif
    );

    spm_seq_mult #(.WIDTH(W), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_r[1]), .x(x_r[1]), .y(y_r[1]),
        .y_ready(y_ready_w[1]), .busy(busy_w[1]), .p(p_w[1]),
        .p_valid(pv_w[1]), .done(done_w[1])
`ifdef SPM_PAR_OUT_EN
        , .p_par(ppar_w[1])
`endif
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] exp_q [2][$];
    int             abort_req [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer multiply, truncated to 2*W bits.
    function automatic logic [2*W-1:0] model(input bit sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, pr;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[W-1]) sa = sa - (longint'(1) << W);
        if (sgn && b[W-1]) sb = sb - (longint'(1) << W);
        pr = sa * sb;
        return pr[2*W-1:0];
    endfunction

    // Monitors: assemble the serial stream and compare against the scoreboard.
    for (genvar g = 0; g < 2; g++) begin : mon
        int             idx = 0;
        int             abort_seen = 0;
        logic [2*W-1:0] acc = '0;
        logic [2*W-1:0] want;
`ifdef SPM_PAR_OUT_EN
        bit             hold_pending = 0;
        logic [2*W-1:0] hold_val;
`endif
        always @(negedge clk) begin
`ifdef SPM_PAR_OUT_EN
            if (hold_pending) begin
                chk("p_par_hold", ppar_w[g], hold_val);
                hold_pending = 0;
            end
`endif
            if (done_w[g]) chk("done_with_valid", pv_w[g], 1'b1);
            if (pv_w[g] === 1'b1) begin
                if (idx >= 2*W) begin
                    chk("done_missing_idx", idx, 2*W-1);
                    idx = 0;
                end
                acc[idx] = p_w[g];
                if (done_w[g]) begin
                    chk("done_index", idx, 2*W-1);
                    chk("scoreboard_nonempty", exp_q[g].size() != 0, 1'b1);
                    if (exp_q[g].size() != 0) begin
                        want = exp_q[g].pop_front();
                        chk($sformatf("product_dut%0d", g), acc, want);
`ifdef SPM_PAR_OUT_EN
                        chk("p_par_done", ppar_w[g], want);
                        hold_val     = want;
                        hold_pending = 1;
`endif
                    end
                    idx = 0;
                end else begin
                    idx++;
                end
            end else if (idx != 0) begin
                if (abort_req[g] > abort_seen) abort_seen++;
                else chk("stream_truncated_idx", idx, 0);
                idx = 0;
            end
        end
    end

    // One multiply on DUT sel. pulse_extra re-asserts start mid-operation;
    // abort_at > 0 pulls reset low in that cycle instead of finishing.
    task automatic run_op(input int sel, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input bit pulse_extra, input int abort_at);
        @(negedge clk);
        chk("idle_before_start", busy_w[sel], 1'b0);
        start_r[sel] = 1'b1;
        x_r[sel]     = xv;
        y_r[sel]     = 1'(($urandom));
        if (abort_at == 0) exp_q[sel].push_back(model(sel == 1, xv, yv));
        else abort_req[sel]++;
        for (int c = 1; c <= 2*W+1; c++) begin
            @(negedge clk);
            start_r[sel] = pulse_extra && (c == 5 || c == 10);
            x_r[sel]     = W'($urandom);
            y_r[sel]     = (c <= W) ? yv[c-1] : 1'($urandom);
            chk("y_ready", y_ready_w[sel], (c <= W));
            chk("busy", busy_w[sel], 1'b1);
            chk("p_valid", pv_w[sel], (c >= 2));
            chk("done", done_w[sel], (c == 2*W+1));
            if (c == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy_w[sel], 1'b0);
                chk("abort_p_valid", pv_w[sel], 1'b0);
                chk("abort_p", p_w[sel], 1'b0);
                chk("abort_done", done_w[sel], 1'b0);
                rst          = 1'b1;
                start_r[sel] = 1'b0;
                return;
            end
        end
        start_r[sel] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start_r[g] = 1'b0; y_r[g] = 1'b0; x_r[g] = '0; abort_req[g] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_y_ready", y_ready_w[g], 1'b0);
            chk("rst_busy", busy_w[g], 1'b0);
            chk("rst_p", p_w[g], 1'b0);
            chk("rst_p_valid", pv_w[g], 1'b0);
            chk("rst_done", done_w[g], 1'b0);
`ifdef SPM_PAR_OUT_EN
            chk("rst_p_par", ppar_w[g], '0);
`endif
        end
        rst = 1'b1;

        run_op(0, 8'd13, 8'd11, 0, 0);
        run_op(0, 8'd255, 8'd255, 0, 0);
        run_op(1, 8'hFD, 8'd5, 0, 0);
        run_op(1, 8'h80, 8'h80, 0, 0);
        run_op(0, 8'h5A, 8'hC3, 1, 0);
        run_op(0, 8'h21, 8'h07, 0, 0);
        run_op(1, 8'h7F, 8'h81, 1, 0);
        run_op(0, 8'hA5, 8'h3C, 0, 7);
        run_op(0, 8'd200, 8'd150, 0, 0);
        run_op(1, 8'h96, 8'hE1, 0, 7);
        run_op(1, 8'h01, 8'hFF, 0, 0);
        for (int g = 0; g < 2; g++) begin
            run_op(g, 8'h00, 8'hFF, 0, 0);
            run_op(g, 8'hFF, 8'h00, 0, 0);
            run_op(g, 8'hFF, 8'h01, 0, 0);
        end
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                   1'($urandom), 0);
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("tail_busy", busy_w[g], 1'b0);
                chk("tail_done", done_w[g], 1'b0);
            end
        end
        for (int g = 0; g < 2; g++) chk("scoreboard_drained", exp_q[g].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit: report and stop if the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=%0d required=<200000 cycles", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spm_seq_mult.md
Name: spm_seq_mult

Overview:
Parametrised serial-parallel multiplier, the successor to the fixed spm carry-save array. It takes a WIDTH-bit parallel multiplicand x and a serial multiplier y (LSB first), and emits a 2*WIDTH-bit product serially (LSB first). It adds a start/done handshake, a bit counter with a control FSM, and signed/unsigned mode. It sits between a serial data source and a serial consumer; its carry-save cells are the per-bit partitions checked by the equivalence flow.

Parameters:
WIDTH, 8, multiplicand/multiplier width in bits; legal range 2..64.
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement x and y.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  reset; synchronous, active-low (rst==0 at a clk edge resets).
start  input  1  request a multiply; accepted only in IDLE.
x  input  WIDTH  parallel multiplicand; sampled on the start-accept edge only.
y  input  1  serial multiplier bit; sampled on edges where y_ready==1.
y_ready  output  1  y is sampled at the end of this cycle.
busy  output  1  operation in progress.
p  output  1  serial product bit.
p_valid  output  1  p holds a valid product bit.
done  output  1  one-cycle pulse with the last product bit.

Behaviour:
- Reset (rst==0): state IDLE, counter=0, x_reg=0, all sum/carry cells=0. Outputs y_ready, busy, p, p_valid and done are all 0. A reset mid-operation aborts the multiply; no done is issued.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: on start==1, capture x into x_reg, clear the cell array, set counter=0, go to RUN. With start==0, stay in IDLE.
- Cycle numbering: the start-accept cycle is cycle 0.
- RUN lasts cycles 1..2*WIDTH; the counter increments every cycle.
  - Cycles 1..WIDTH: y_ready=1; y bit k is sampled in cycle k+1.
  - Cycles WIDTH+1..2*WIDTH: y_ready=0; the array is fed an extension bit.
  - Extension bit: 0 if SIGNED==0; the last sampled y bit (sign) if SIGNED==1.
- Per cycle: each cell i computes sum/carry of (x_reg[i] & ybit) + sum[i+1] + carry[i].
  - For SIGNED==1, the MSB cell feeds back its own sum, i.e. arithmetic sign extension of the partial sum.
  - The cell-0 sum is registered to p.
- Output timing: product bit k (k = 0..2*WIDTH-1) is on p with p_valid=1 in cycle k+2, so there is 2 cycles of latency from start accept to bit 0.
- DRAIN: cycle 2*WIDTH+1. The last bit is presented with done=1, then the FSM returns to IDLE.
- busy=1 in cycles 1..2*WIDTH+1.
- Result: the p stream equals the low 2*WIDTH bits of x*y, unsigned or two's-complement per SIGNED. There is no overflow; the full product fits.
- start while busy is ignored and does not affect the result. The earliest next accept is cycle 2*WIDTH+2.
- x changes after accept have no effect; y is ignored while y_ready==0.
- Counter width is clog2(2*WIDTH+2) bits; it never wraps within an operation.

Optional Feature:
Macro: SPM_PAR_OUT_EN.
- Defined:
  - Adds output p_par [2*WIDTH-1:0].
  - Each product bit is shifted into a 2*WIDTH shift register as it is emitted.
  - p_par holds the complete product, stable from the done cycle until the next start accept. It resets to 0.
- Not defined: port and register are absent; serial behaviour is identical.

Test Plan:
1. WIDTH=8, SIGNED=0, x=13, y=11 -> p stream over cycles 2..17 = 0x008F (143) LSB first; done in cycle 17.
2. WIDTH=8, SIGNED=0, x=255, y=255 -> product 0xFE01; y_ready high exactly cycles 1..8.
3. WIDTH=8, SIGNED=1, x=-3 (0xFD), y=5 -> 0xFFF1. Then x=-128, y=-128 -> 0x4000.
4. start pulsed again in cycles 5 and 10 with different x -> first result unchanged, no extra done; back-to-back start at cycle 18 is accepted.
5. rst=0 at cycle 7 of an operation -> next cycle busy=0, p_valid=0, p=0, no done; a fresh multiply afterwards is correct.
6. SPM_PAR_OUT_EN defined, x=200, y=150 (unsigned) -> p_par=0x7530 from the done cycle, held until the next accept.
